// File: rtl/i2c_sht40_target.sv
// i2c_sht40_target: oversampled I2C target that emulates an SHT40 (6-byte T/RH frames).
// Optional macro I2C_TARGET_CRC_EN: frame bytes 2 and 5 carry CRC-8, otherwise 8'hFF.
module i2c_sht40_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         SYNC_STAGES = 2,
  parameter int         READ_BYTES  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Scl_In,
  input  logic        Sda_In,
  output logic        Sda_Pull_Low,
  input  logic [15:0] Temp_Data,
  input  logic [15:0] Hum_Data,
  output logic [7:0]  Cmd_Byte,
  output logic        Cmd_Valid,
  output logic        Busy
);

  // state      | meaning
  // IDLE       | bus ignored until START
  // ADDR       | shifting in 7-bit address + R/W
  // ADDR_ACK   | pulling SDA low for the address ACK
  // CMD        | shifting in a command byte
  // CMD_ACK    | pulling SDA low for the command ACK
  // TX         | driving frame bits on SCL falls
  // TX_ACK     | released, sampling master ACK/NACK
  // WAIT_STOP  | released, waiting for STOP or START
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_t;

  localparam int IDX_W = $clog2(READ_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(READ_BYTES);

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [IDX_W-1:0] r_byte_idx, w_byte_idx_nxt;
  logic [47:0]      r_frame, w_frame_nxt;
  logic [7:0]       r_cmd_byte, w_cmd_byte_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic             r_sda_pull, w_sda_pull_nxt;
  logic             r_busy, w_busy_nxt;
  logic [7:0]       w_tx_byte, w_crc_t, w_crc_h;
  logic             w_addr_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], Scl_In};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], Sda_In};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;
  assign w_addr_hit = (r_shift[7:1] == TARGET_ADDR);

`ifdef I2C_TARGET_CRC_EN
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      c = (c[7] ^ d[i]) ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction
  assign w_crc_t = crc8(Temp_Data);
  assign w_crc_h = crc8(Hum_Data);
`else
  assign w_crc_t = 8'hFF;
  assign w_crc_h = 8'hFF;
`endif

  // Indices past the frame (saturated) read as all-ones, i.e. SDA released.
  always_comb begin
    w_tx_byte = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (i < READ_BYTES && r_byte_idx == IDX_W'(i)) w_tx_byte = r_frame[47-8*i -: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_byte_idx  <= '0;
      r_frame     <= '0;
      r_cmd_byte  <= '0;
      r_cmd_valid <= 1'b0;
      r_sda_pull  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_frame     <= w_frame_nxt;
      r_cmd_byte  <= w_cmd_byte_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_sda_pull  <= w_sda_pull_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = S_ADDR;
    else if (w_stop) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_ADDR:     if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? S_TX : S_CMD;
        S_CMD:      if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_CMD_ACK;
        S_CMD_ACK:  if (w_scl_fall) w_state_nxt = S_CMD;
        S_TX:       if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = S_TX_ACK;
        S_TX_ACK:   if (w_scl_rise) w_state_nxt = w_sda ? S_WAIT_STOP : S_TX;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_byte_idx_nxt  = r_byte_idx;
    w_frame_nxt     = r_frame;
    w_cmd_byte_nxt  = r_cmd_byte;
    w_cmd_valid_nxt = 1'b0;
    w_sda_pull_nxt  = r_sda_pull;
    w_busy_nxt      = r_busy;
    if (w_start) begin
      w_sda_pull_nxt = 1'b0;
      w_bit_cnt_nxt  = '0;
    end else if (w_stop) begin
      w_sda_pull_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_CMD: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_bit_cnt_nxt = '0;
            if (r_state == S_CMD) begin
              w_cmd_byte_nxt  = r_shift;
              w_cmd_valid_nxt = 1'b1;
              w_sda_pull_nxt  = 1'b1;
            end else if (w_addr_hit) begin
              w_sda_pull_nxt = 1'b1;
              w_busy_nxt     = 1'b1;
            end
          end
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          if (r_shift[0]) begin
            // Frame is captured here so all six bytes come from one coherent sample.
            w_frame_nxt    = {Temp_Data, w_crc_t, Hum_Data, w_crc_h};
            w_byte_idx_nxt = '0;
            w_sda_pull_nxt = (READ_BYTES > 0) ? ~Temp_Data[15] : 1'b0;
            w_bit_cnt_nxt  = 4'd1;
          end else begin
            w_sda_pull_nxt = 1'b0;
            w_bit_cnt_nxt  = '0;
          end
        end
        S_CMD_ACK: if (w_scl_fall) w_sda_pull_nxt = 1'b0;
        S_TX: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) w_sda_pull_nxt = 1'b0;
          else begin
            w_sda_pull_nxt = ~w_tx_byte[~r_bit_cnt[2:0]];
            w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
          end
        end
        S_TX_ACK: if (w_scl_rise) begin
          w_bit_cnt_nxt = '0;
          if (!w_sda && r_byte_idx != LAST_IDX) w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
        end
        default: w_sda_pull_nxt = 1'b0;
      endcase
    end
    if (w_state_nxt == S_IDLE) w_busy_nxt = 1'b0;
  end

  assign Sda_Pull_Low = r_sda_pull;
  assign Cmd_Byte     = r_cmd_byte;
  assign Cmd_Valid    = r_cmd_valid;
  assign Busy         = r_busy;

endmodule

// File: tb/tb_i2c_sht40_target.sv
// Directed bench for i2c_sht40_target: open-drain bus model plus a bit-banged I2C master.
module tb_i2c_sht40_target;

  logic        clk, rst_n, m_scl, m_sda;
  logic        sda_line, sda_pull;
  logic [15:0] temp_data, hum_data;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, busy;
  int          n_total = 0, n_pass = 0, cv_cnt = 0;
  logic        ack;
  logic [7:0]  rd;

`ifdef I2C_TARGET_CRC_EN
  localparam logic [7:0] EXP_TCRC = 8'h92, EXP_HCRC = 8'h37;
`else
  localparam logic [7:0] EXP_TCRC = 8'hFF, EXP_HCRC = 8'hFF;
`endif

  assign sda_line = m_sda & ~sda_pull;

  i2c_sht40_target dut (
    .clk(clk), .rst_n(rst_n), .Scl_In(m_scl), .Sda_In(sda_line), .Sda_Pull_Low(sda_pull),
    .Temp_Data(temp_data), .Hum_Data(hum_data), .Cmd_Byte(cmd_byte), .Cmd_Valid(cmd_valid),
    .Busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (cmd_valid) cv_cnt++;

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(10);
    m_scl = 1'b1; wq(10);
    m_sda = 1'b0; wq(10);
    m_scl = 1'b0; wq(10);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(10);
    m_scl = 1'b1; wq(10);
    m_sda = 1'b1; wq(10);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wq(10);
    m_scl = 1'b1; wq(20);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    wq(10);
    m_sda = 1'b1; wq(10);
    m_scl = 1'b1; wq(10);
    a = sda_line; wq(10);
    m_scl = 1'b0; wq(10);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    d = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_scl = 1'b1; wq(10);
      d = {d[6:0], sda_line}; wq(10);
      m_scl = 1'b0; wq(10);
    end
    m_sda = ~master_ack; wq(10);
    m_scl = 1'b1; wq(20);
    m_scl = 1'b0; wq(10);
    m_sda = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_frame [0:6];
    exp_frame[0] = 8'hBE; exp_frame[1] = 8'hEF; exp_frame[2] = EXP_TCRC;
    exp_frame[3] = 8'h12; exp_frame[4] = 8'h34; exp_frame[5] = EXP_HCRC;
    exp_frame[6] = 8'hFF;
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    temp_data = 16'hBEEF; hum_data = 16'h1234;
    wq(3);
    check("rst_pull", sda_pull, 0);
    check("rst_cmd", cmd_byte, 8'h00);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1; wq(5);

    // write address 0x44 + command 0xFD
    i2c_start();
    write_byte(8'h88, ack); check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    write_byte(8'hFD, ack); check("wr_cmd_ack", ack, 0);
    check("wr_cmd_byte", cmd_byte, 8'hFD);
    check("wr_cv_once", cv_cnt[15:0], 1);
    i2c_stop();
    check("wr_busy_stop", busy, 0);
    check("wr_pull_stop", sda_pull, 0);

    // wrong address is ignored
    i2c_start();
    write_byte(8'h8A, ack); check("bad_addr_nack", ack, 1);
    check("bad_busy", busy, 0);
    write_byte(8'h55, ack); check("bad_data_nack", ack, 1);
    check("bad_cv", cv_cnt[15:0], 1);
    check("bad_cmd_kept", cmd_byte, 8'hFD);
    i2c_stop();

    // 6-byte read, final NACK
    i2c_start();
    write_byte(8'h89, ack); check("rd6_addr_ack", ack, 0);
    for (int i = 0; i < 6; i++) begin
      read_byte(i != 5, rd);
      check($sformatf("rd6_byte%0d", i), rd, exp_frame[i]);
    end
    i2c_stop();
    check("rd6_busy_stop", busy, 0);

    // 7-byte read: index saturates, extra byte reads as FF
    i2c_start();
    write_byte(8'h89, ack); check("rd7_addr_ack", ack, 0);
    for (int i = 0; i < 7; i++) begin
      read_byte(i != 6, rd);
      check($sformatf("rd7_byte%0d", i), rd, exp_frame[i]);
    end
    i2c_stop();

    // NACK after byte 0: released, waits, then new START accepted
    i2c_start();
    write_byte(8'h89, ack); check("nk_addr_ack", ack, 0);
    read_byte(1'b0, rd); check("nk_byte0", rd, 8'hBE);
    read_byte(1'b0, rd); check("nk_released", rd, 8'hFF);
    check("nk_busy_wait", busy, 1);
    i2c_start();
    write_byte(8'h88, ack); check("nk_restart_ack", ack, 0);
    i2c_stop();

    // repeated START in the middle of a command byte
    i2c_start();
    write_byte(8'h88, ack); check("rs_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    wq(10);
    i2c_start();
    write_byte(8'h89, ack); check("rs_read_ack", ack, 0);
    read_byte(1'b0, rd); check("rs_byte0", rd, 8'hBE);
    check("rs_busy", busy, 1);
    check("rs_cv", cv_cnt[15:0], 1);
    i2c_stop();

    // reset while the target pulls SDA low for bit 6 of 0xBE
    i2c_start();
    write_byte(8'h89, ack); check("rst_tx_addr_ack", ack, 0);
    m_scl = 1'b1; wq(20);
    m_scl = 1'b0;
    for (int i = 0; i < 30 && !sda_pull; i++) wq(1);
    check("rst_tx_pulling", sda_pull, 1);
    rst_n = 1'b0; #1;
    check("rst_tx_released", sda_pull, 0);
    check("rst_tx_busy", busy, 0);
    wq(3); rst_n = 1'b1;
    m_scl = 1'b1; wq(10);
    m_sda = 1'b1; wq(10);
    i2c_start();
    write_byte(8'h88, ack); check("rst_after_ack", ack, 0);
    i2c_stop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
